// File: rtl/dbus_mem.sv
// Data-bus memory responder: word RAM with byte-enable writes, a programmable
// wait-state count, and a single-cycle registered ready pulse per access.
module dbus_mem #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_data_wr,
  input  logic [3:0]  dbus_be,
  input  logic        dbus_rd,
  input  logic        dbus_wr,
  output logic [31:0] dbus_data_rd,
  output logic        dbus_data_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [29:0] cap_idx;
  logic [31:0] cap_data;
  logic [3:0]  cap_be;
  logic        cap_wr;
  logic [29:0] acc_idx;
  logic [31:0] acc_data;
  logic [3:0]  acc_be;
  logic        acc_wr;
  logic        commit;
  logic        in_range;
  logic        addr_lsb_unused;
  logic [31:0] mem [DEPTH];

  assign addr_lsb_unused = ^dbus_addr[1:0];

  // With no wait states the access commits on its capture edge, so the live bus
  // feeds the commit path in IDLE; otherwise the captured copy does.
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    acc_idx    = cap_idx;
    acc_data   = cap_data;
    acc_be     = cap_be;
    acc_wr     = cap_wr;
    case (state)
      IDLE: begin
        acc_idx  = dbus_addr[31:2];
        acc_data = dbus_data_wr;
        acc_be   = dbus_be;
        acc_wr   = dbus_wr;
        if (dbus_rd || dbus_wr) begin
          if (LATENCY > 0) begin
            state_next = WAIT;
          end else begin
            state_next = RESP;
            commit     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_range = {2'b00, acc_idx} < DEPTH;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= 4'd0;
      dbus_data_ready <= 1'b0;
      dbus_data_rd    <= 32'h0;
    end else begin
      state           <= state_next;
      dbus_data_ready <= commit;
      if (state == IDLE) begin
        if (dbus_rd || dbus_wr) begin
          cap_idx  <= dbus_addr[31:2];
          cap_data <= dbus_data_wr;
          cap_be   <= dbus_be;
          cap_wr   <= dbus_wr;
          count    <= 4'(LATENCY);
        end
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (commit && !acc_wr) begin
        dbus_data_rd <= in_range ? mem[acc_idx[AW-1:0]] : 32'h0;
      end
    end
  end

  // RAM contents survive reset; a reset edge only blocks the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && acc_wr && in_range) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (acc_be[lane]) begin
          mem[acc_idx[AW-1:0]][8*lane +: 8] <= acc_data[8*lane +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem.sv
// Scoreboard bench for dbus_mem: three instances (LATENCY 0, 3, 2; DEPTH 16)
// checked against a word-array reference model with a decoupled monitor.
module tb_dbus_mem;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic [3:0]  be_s    [NI];
  logic        rd_s    [NI];
  logic        wr_s    [NI];
  wire  [31:0] rdata0, rdata1, rdata2;
  wire         ready0, ready1, ready2;

  typedef struct {
    int          inst;
    bit          is_read;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mm [NI][16];
  logic [31:0] exp_rd [NI];
  int          cyc = 0;
  logic        rst_sampled = 1'b0;
  bit          armed = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dbus_mem #(.DEPTH(16), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .dbus_addr(addr_s[0]), .dbus_data_wr(wdata_s[0]),
    .dbus_be(be_s[0]), .dbus_rd(rd_s[0]), .dbus_wr(wr_s[0]),
    .dbus_data_rd(rdata0), .dbus_data_ready(ready0));

  dbus_mem #(.DEPTH(16), .LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .dbus_addr(addr_s[1]), .dbus_data_wr(wdata_s[1]),
    .dbus_be(be_s[1]), .dbus_rd(rd_s[1]), .dbus_wr(wr_s[1]),
    .dbus_data_rd(rdata1), .dbus_data_ready(ready1));

  dbus_mem #(.DEPTH(16), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .dbus_addr(addr_s[2]), .dbus_data_wr(wdata_s[2]),
    .dbus_be(be_s[2]), .dbus_rd(rd_s[2]), .dbus_wr(wr_s[2]),
    .dbus_data_rd(rdata2), .dbus_data_ready(ready2));

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 2;
  endfunction

  // Reference model: a plain 16-word array per instance; writes win over reads.
  function automatic void model_access(input int d, input bit do_wr,
                                       input logic [31:0] a, input logic [31:0] data,
                                       input logic [3:0] b, output bit is_rd,
                                       output logic [31:0] val);
    int idx;
    idx   = int'(a >> 2);
    is_rd = !do_wr;
    val   = 32'h0;
    if (do_wr) begin
      if (idx < 16) begin
        for (int l = 0; l < 4; l++) begin
          if (b[l]) mm[d][idx][8*l +: 8] = data[8*l +: 8];
        end
      end
    end else begin
      val = (idx < 16) ? mm[d][idx] : 32'h0;
    end
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, d, cyc, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_sampled <= reset;
  end

  // Monitor: every cycle, each instance's ready must match the scoreboard head
  // and its read data must hold the last read response (zero after reset).
  always @(negedge clk) begin
    logic [31:0] rd_now [NI];
    logic        rdy_now [NI];
    bit          exp_rdy;
    exp_t        e;
    rd_now  = '{rdata0, rdata1, rdata2};
    rdy_now = '{ready0, ready1, ready2};
    if (rst_sampled) begin
      for (int d = 0; d < NI; d++) exp_rd[d] = 32'h0;
      armed = 1'b1;
    end
    if (armed) begin
      for (int d = 0; d < NI; d++) begin
        exp_rdy = (sbq.size() != 0) && (sbq[0].inst == d) && (sbq[0].due == cyc);
        checkOutput("ready", d, {31'b0, rdy_now[d]}, {31'b0, exp_rdy});
        if (exp_rdy) begin
          e = sbq.pop_front();
          if (e.is_read) exp_rd[d] = e.data;
        end
        checkOutput("data_rd", d, rd_now[d], exp_rd[d]);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain", -1, 32'(sbq.size()), 32'h0);
    sbq.delete();
  endtask

  task automatic push_exp(input int d, input bit is_rd, input logic [31:0] val, input int due);
    exp_t e;
    e.inst    = d;
    e.is_read = is_rd;
    e.data    = val;
    e.due     = due;
    sbq.push_back(e);
  endtask

  // One access; with noise set, the bus is scribbled on for the whole WAIT window.
  task automatic applyStimulus(input int d, input bit do_wr, input bit do_rd,
                               input logic [31:0] a, input logic [31:0] data,
                               input logic [3:0] b, input bit noise);
    bit          is_rd;
    logic [31:0] val;
    @(posedge clk); #1;
    addr_s[d]  = a;
    wdata_s[d] = data;
    be_s[d]    = b;
    rd_s[d]    = do_rd;
    wr_s[d]    = do_wr;
    model_access(d, do_wr, a, data, b, is_rd, val);
    push_exp(d, is_rd, val, cyc + 1 + lat_of(d));
    @(posedge clk); #1;
    if (noise) begin
      for (int k = 0; k < lat_of(d); k++) begin
        addr_s[d]  = (k % 2 == 0) ? 32'h14 : 32'h18;
        wr_s[d]    = (k % 2 == 0);
        rd_s[d]    = 1'b0;
        wdata_s[d] = $urandom;
        be_s[d]    = 4'hF;
        @(posedge clk); #1;
      end
    end
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          d;
    int          kind;
    logic [31:0] a;
    int          c0;
    for (int i = 0; i < NI; i++) begin
      addr_s[i] = 32'h0; wdata_s[i] = 32'h0; be_s[i] = 4'h0; rd_s[i] = 1'b0; wr_s[i] = 1'b0;
    end
    // Reset held with a read request pending on instance 0
    rd_s[0]   = 1'b1;
    addr_s[0] = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    rd_s[0] = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 16; k++)
        applyStimulus(i, 1'b1, 1'b0, 32'(k * 4), $urandom, 4'hF, 1'b0);

    // Instance 0, no wait states: basic, byte lanes, out of range, both strobes
    applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h13, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 4'hF, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h20, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h77777777, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h00, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b1, 32'h04, 32'h5, 4'hF, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h04, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0, 32'h08, 32'hFFFFFFFF, 4'h0, 1'b0);
    applyStimulus(0, 1'b0, 1'b1, 32'h08, 32'h0, 4'h0, 1'b0);

    // Instance 1: bus changes during WAIT must be ignored
    applyStimulus(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'h0, 1'b1);
    applyStimulus(1, 1'b0, 1'b1, 32'h14, 32'h0, 4'h0, 1'b0);
    applyStimulus(1, 1'b0, 1'b1, 32'h18, 32'h0, 4'h0, 1'b0);

    // Instance 2: reset during WAIT abandons the write and its ready pulse
    @(posedge clk); #1;
    wr_s[2] = 1'b1; addr_s[2] = 32'h08; wdata_s[2] = 32'hCAFEF00D; be_s[2] = 4'hF;
    @(posedge clk); #1;
    wr_s[2] = 1'b0;
    reset   = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    applyStimulus(2, 1'b0, 1'b1, 32'h08, 32'h0, 4'h0, 1'b0);

    // Instance 2: a held read yields two responses LATENCY+2 cycles apart
    @(posedge clk); #1;
    c0 = cyc;
    rd_s[2] = 1'b1; addr_s[2] = 32'h0C;
    push_exp(2, 1'b1, mm[2][3], c0 + 3);
    push_exp(2, 1'b1, mm[2][3], c0 + 7);
    repeat (5) @(posedge clk);
    #1;
    rd_s[2] = 1'b0;
    wait_drain();

    for (int i = 0; i < 90; i++) begin
      d    = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      a    = (32'($urandom_range(0, 19)) << 2) | (32'($urandom) & 32'h3);
      applyStimulus(d, (kind == 1) || (kind == 2), (kind != 1), a, $urandom,
                    4'($urandom), 1'b0);
    end

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_mem.md
# dbus_mem

Synchronous data-memory responder for the core's data bus (dbus). The pipeline is the initiator: it drives address, write data, byte enables and a read or write strobe, then waits for `dbus_data_ready`. This block is the responder. It holds a word-organised RAM, inserts a programmable wait-state count, commits writes with byte enables, and returns read data with a single-cycle ready pulse.

## Interface
- `DEPTH`, default 1024: RAM size in 32-bit words. Word index is `dbus_addr[31:2]`.
- `LATENCY`, default 1: wait states between request capture and response. Legal range 0..15.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; one clock domain. Both are fixed.
- `dbus_addr`  in  32  byte address. Bits [1:0] are ignored; all accesses are word-aligned.
- `dbus_data_wr`  in  32  write data.
- `dbus_be`  in  4  byte write enables. Bit n enables byte lane [8n+7:8n].
- `dbus_rd`  in  1  read request.
- `dbus_wr`  in  1  write request.
- `dbus_data_rd`  out  32  read data. Valid while `dbus_data_ready` is high.
- `dbus_data_ready`  out  1  one-cycle response pulse.

## Operation
- State machine with three states: IDLE, WAIT, RESP.
- **IDLE**
  - At a clock edge where `dbus_rd` or `dbus_wr` is high, capture addr, data, be, and kind (write wins if both are high).
  - Load the wait counter with `LATENCY`.
  - Next state is WAIT if `LATENCY` > 0, else RESP.
- **WAIT**
  - Decrement the counter each cycle.
  - Go to RESP on the edge where the counter equals 1.
  - Bus inputs are ignored; only the captured values are used.
- **Entry to RESP** (a single edge):
  - For a write, each lane with be=1 is written to `mem[idx]`. Lanes with be=0 are unchanged.
  - For a read, `dbus_data_rd` is loaded with `mem[idx]`, reflecting all earlier committed writes.
  - `dbus_data_ready` is registered high.
- **RESP**: lasts exactly one cycle, then returns to IDLE unconditionally. Requests are not sampled on the RESP→IDLE edge.
- The initiator must drop or replace its request on the edge where it samples ready high. A request still held in the IDLE cycle is treated as a new access.
- **Out of range** (idx >= `DEPTH`):
  - A read returns 0.
  - A write is dropped and memory is unchanged.
  - The ready pulse still occurs. Addresses do not alias.
- **Simultaneous `dbus_rd` and `dbus_wr`**: treated as a write. `dbus_data_rd` is not updated, and ready pulses once.
- **`dbus_data_rd` hold**: it changes only on a read response and holds its value otherwise, including after ready falls.
- **Write with be=0000**: legal no-op; ready still pulses.
- **Reset**
  - Forces IDLE, `dbus_data_ready`=0 and `dbus_data_rd`=0, and clears the counter.
  - An in-flight access is abandoned: a write not yet committed is lost, and no ready pulse is produced.
  - RAM contents are not reset.

## Timing
- **Reset values**: `dbus_data_ready`=0, `dbus_data_rd`=0x00000000, state IDLE.
- **Request to ready**: request visible in cycle 0, ready high in cycle 1+`LATENCY`.
  - `LATENCY`=0 gives ready in cycle 1.
  - `LATENCY`=3 gives ready in cycle 4.
- **Throughput**: back-to-back accesses complete every `LATENCY`+2 cycles. The cycle after RESP is always IDLE.
- **Outputs**: all driven directly from flops; there is no combinational path from inputs to outputs.
- **Read-after-write**: a read issued after the write's ready pulse returns the new data.

## Test plan
- **Reset and idle.** Hold reset 3 cycles with `dbus_rd`=1, then release with rd=0. Required: ready stays 0 and `dbus_data_rd`=0 throughout.
- **Write then read, LATENCY=0.**
  - Write 0xDEADBEEF with be=1111 to addr 0x10: ready in cycle 1.
  - Read addr 0x13: ready in cycle 1 with data 0xDEADBEEF.
- **Byte enables.**
  - Preload 0x11223344 at addr 0x20.
  - Write 0xAABBCCDD with be=0101.
  - Read back: required 0x11BB33DD.
- **LATENCY=3 and input changes during WAIT.**
  - Issue a read of addr 0x10.
  - Toggle `dbus_addr` and `dbus_wr` during WAIT.
  - Required: ready only in cycle 4, data from 0x10, no write committed.
- **Out of range and simultaneous strobes (DEPTH=16).**
  - Write to addr 0x40 (idx 16): ready pulses; a read of 0x00 is unchanged.
  - Read addr 0x40: returns 0.
  - rd=wr=1 to 0x04 with data 0x5: memory[1]=5 and `dbus_data_rd` is unchanged.
- **Reset mid-operation (LATENCY=2).**
  - Start a write of 0xCAFEF00D to 0x08 and assert reset in the WAIT cycle.
  - Required: no ready pulse, and a subsequent read of 0x08 returns the pre-write value.
  - Back-to-back: two reads held continuously yield ready pulses exactly `LATENCY`+2 cycles apart.
